// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch constants and FSM encoding
package fetch_stage_pkg;
  localparam int PC_W = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DRAIN} state_e;
endpackage

// File: rtl/fetch_stage_hold_buffer.sv
// fetch_hold_buffer: one-entry slot parking a response that arrived under stall
module fetch_hold_buffer
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [31:0]     d_instr,
  input  logic [PC_W-1:0] d_pc,
  output logic [31:0]     q_instr,
  output logic [PC_W-1:0] q_pc,
  output logic            full
);
  logic [31:0] instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic full_q, full_d;
  always_comb begin
    full_d  = (unload || clear) ? 1'b0 : load ? 1'b1 : full_q;
    instr_d = load ? d_instr : instr_q;
    pc_d    = load ? d_pc : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
  assign q_instr = instr_q;
  assign q_pc    = pc_q;
  assign full    = full_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch feeding decode, with stall hold
// and jump squash of wrong-path responses.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jmp_taken,
  input  logic [PC_W-1:0] jmp_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid
);
  state_e state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, pc_q, pc_d, buf_pc;
  logic [31:0] instr_q, instr_d, buf_instr;
  logic instr_valid_q, instr_valid_d;
  logic resp, take, unload, buf_load, buf_full;
  fetch_hold_buffer u_hold (
    .clk(clk), .rst(rst), .load(buf_load), .unload(unload), .clear(jmp_taken),
    .d_instr(imem_rdata), .d_pc(fetch_pc_q),
    .q_instr(buf_instr), .q_pc(buf_pc), .full(buf_full)
  );
  always_comb begin
    resp     = imem_valid && (state_q == WAIT);
    take     = resp && !stall && !jmp_taken;
    unload   = (state_q == HOLD) && buf_full && !stall;
    buf_load = resp && stall && !jmp_taken;
    state_d  = state_q;
    case (state_q)
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = imem_valid ? (stall ? HOLD : ISSUE) : WAIT;
      HOLD:    state_d = unload ? ISSUE : HOLD;
      default: state_d = imem_valid ? ISSUE : DRAIN;
    endcase
    // a redirect leaves one in-flight request behind unless its response is here now
    if (jmp_taken)
      state_d = (state_q == HOLD || (imem_valid && state_q != ISSUE)) ? ISSUE : DRAIN;
    fetch_pc_d = jmp_taken ? (jmp_target & ~PC_W'(3)) : resp ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
    instr_d       = (jmp_taken || !stall) ? NOP_INSTR : instr_q;
    instr_valid_d = (jmp_taken || !stall) ? 1'b0 : instr_valid_q;
    pc_d          = pc_q;
    if (take) begin
      instr_d       = imem_rdata;
      pc_d          = fetch_pc_q;
      instr_valid_d = 1'b1;
    end
    if (unload && !jmp_taken) begin
      instr_d       = buf_instr;
      pc_d          = buf_pc;
      instr_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ISSUE;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      if (imem_valid) assert (state_q == WAIT || state_q == DRAIN);
    end
  end
  assign imem_req    = (state_q == ISSUE) && !rst;
  assign imem_addr   = imem_req ? fetch_pc_q : '0;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
endmodule
